// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter: captures sample pairs on the engine frame strobe into a
// one-deep pending buffer and serialises them MSB-first with the I2S one-bit delay.
module i2s_audio_tx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                     AUDIO_CLK,
  input  logic                     reset_reg_N,
  input  logic                     sample_strobe,
  input  logic signed [DATA_W-1:0] lsound_in,
  input  logic signed [DATA_W-1:0] rsound_in,
  input  logic                     clear_flags,
  output logic                     i2s_bclk,
  output logic                     i2s_lrck,
  output logic                     i2s_data,
  output logic                     frame_load,
  output logic                     underrun,
  output logic                     overrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  // Left-align a sample in its slot; the unused low bits stay zero.
  function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_W-1:0] s);
    logic [SLOT_W-1:0] r;
    r = '0;
    r[SLOT_W-1 -: DATA_W] = s;
    return r;
  endfunction

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] pend_l, pend_r;
  logic [DATA_W-1:0] tx_l, tx_r;
  logic              pending_valid;
  logic              armed;

  logic              fall;
  logic              load;
  logic [DIV_W-1:0]  div_nxt;
  logic [BIT_W-1:0]  bit_nxt;
  logic [BIT_W-1:0]  frame_idx;
  logic [DATA_W-1:0] tx_l_nxt, tx_r_nxt;
  logic [FRAME_W-1:0] frame_nxt;
  logic              data_nxt;
  logic              pv_nxt;
  logic              underrun_nxt;
  logic              overrun_nxt;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    fall         = (div_cnt == DIV_LAST);
    load         = fall && (bit_cnt == '0);
    div_nxt      = fall ? '0 : div_cnt + DIV_ONE;
    bit_nxt      = bit_cnt;
    tx_l_nxt     = tx_l;
    tx_r_nxt     = tx_r;
    pv_nxt       = pending_valid;
    underrun_nxt = underrun;
    overrun_nxt  = overrun;

    if (fall) begin
      bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
    end

    // Load takes the pending pair first; with nothing pending a same-cycle
    // strobe is passed straight through, otherwise the old pair repeats.
    if (load) begin
      if (pending_valid) begin
        tx_l_nxt = pend_l;
        tx_r_nxt = pend_r;
      end else if (sample_strobe) begin
        tx_l_nxt = lsound_in;
        tx_r_nxt = rsound_in;
      end
    end

    if (sample_strobe) begin
      pv_nxt = pending_valid | ~load;
    end else if (load) begin
      pv_nxt = 1'b0;
    end

    // Clear is applied first so a same-cycle set overrides it.
    if (clear_flags) begin
      underrun_nxt = 1'b0;
      overrun_nxt  = 1'b0;
    end
    if (load && !pending_valid && !sample_strobe && armed) begin
      underrun_nxt = 1'b1;
    end
    if (sample_strobe && pending_valid && !load) begin
      overrun_nxt = 1'b1;
    end

    // One-bit delay: during bit_cnt = b the line carries frame bit b-1.
    frame_nxt = {to_slot(tx_l_nxt), to_slot(tx_r_nxt)};
    frame_idx = (bit_nxt == '0) ? BIT_LAST : bit_nxt - BIT_ONE;
    data_nxt  = frame_nxt[BIT_LAST - frame_idx];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      div_cnt       <= '0;
      bit_cnt       <= '0;
      pend_l        <= '0;
      pend_r        <= '0;
      tx_l          <= '0;
      tx_r          <= '0;
      pending_valid <= 1'b0;
      armed         <= 1'b0;
      i2s_bclk      <= 1'b0;
      i2s_lrck      <= 1'b0;
      i2s_data      <= 1'b0;
      frame_load    <= 1'b0;
      underrun      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      div_cnt       <= div_nxt;
      bit_cnt       <= bit_nxt;
      tx_l          <= tx_l_nxt;
      tx_r          <= tx_r_nxt;
      pending_valid <= pv_nxt;
      armed         <= armed | sample_strobe;
      if (sample_strobe) begin
        pend_l <= lsound_in;
        pend_r <= rsound_in;
      end
      i2s_bclk      <= (div_nxt >= DIV_HALF);
      i2s_lrck      <= (bit_nxt >= BIT_SLOT);
      i2s_data      <= data_nxt;
      frame_load    <= load;
      underrun      <= underrun_nxt;
      overrun       <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: default build plus a BCLK_DIV=2, DATA_W=32 build.
module tb_i2s_audio_tx;

  logic        clk;
  logic        rst_n;
  logic        strobe, clear;
  logic [23:0] l_in, r_in;
  logic        bclk, lrck, data, fload, und, ovr;

  logic        w_strobe, w_clear;
  logic [31:0] w_l, w_r;
  logic        w_bclk, w_lrck, w_data, w_fload, w_und, w_ovr;

  int tests;
  int fails;

  i2s_audio_tx dut (
    .AUDIO_CLK(clk), .reset_reg_N(rst_n), .sample_strobe(strobe),
    .lsound_in(l_in), .rsound_in(r_in), .clear_flags(clear),
    .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_data(data),
    .frame_load(fload), .underrun(und), .overrun(ovr)
  );

  i2s_audio_tx #(.DATA_W(32), .SLOT_W(32), .BCLK_DIV(2)) dut_w (
    .AUDIO_CLK(clk), .reset_reg_N(rst_n), .sample_strobe(w_strobe),
    .lsound_in(w_l), .rsound_in(w_r), .clear_flags(w_clear),
    .i2s_bclk(w_bclk), .i2s_lrck(w_lrck), .i2s_data(w_data),
    .frame_load(w_fload), .underrun(w_und), .overrun(w_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    strobe = 1'b0; clear = 1'b0; l_in = '0; r_in = '0;
    w_strobe = 1'b0; w_clear = 1'b0; w_l = '0; w_r = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_strobe(input logic [23:0] l, input logic [23:0] r);
    strobe = 1'b1; l_in = l; r_in = r;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  // Returns at the negedge on which frame_load is high; n = negedges waited.
  task automatic wait_load(input bit wide, input int limit, output int n);
    bit found;
    n = 0; found = 1'b0;
    while (n < limit && !found) begin
      @(negedge clk);
      n++;
      found = wide ? w_fload : fload;
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL wait_load: no frame_load within %0d cycles", limit);
    end
  endtask

  // Called on the frame_load negedge; samples each frame bit at BCLK rise.
  task automatic capture(input bit wide, output logic [63:0] frame, output logic [63:0] lr);
    int div;
    div = wide ? 2 : 4;
    repeat (div / 2) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      frame[63-i] = wide ? w_data : data;
      lr[63-i]    = wide ? w_lrck : lrck;
      if (i < 63) repeat (div) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    strobe = 1'b0; clear = 1'b0; l_in = '0; r_in = '0;
    w_strobe = 1'b0; w_clear = 1'b0; w_l = '0; w_r = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bclk, lrck, data, fload, und, ovr} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000000", {bclk, lrck, data, fload, und, ovr});
    end
    tests++;
    if ({w_bclk, w_lrck, w_data, w_fload, w_und, w_ovr} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs_wide: got %b expected 000000",
               {w_bclk, w_lrck, w_data, w_fload, w_und, w_ovr});
    end
  endtask

  task automatic test_basic();
    logic [63:0] fr, lr;
    int n;
    do_reset();
    pulse_strobe(24'h800001, 24'h7FFFFE);
    wait_load(1'b0, 20, n);
    capture(1'b0, fr, lr);
    tests++;
    if (fr !== 64'h80000100_7FFFFE00) begin
      fails++; $display("FAIL basic_frame: got %h expected %h", fr, 64'h80000100_7FFFFE00);
    end
    tests++;
    if (lr !== 64'h00000001_FFFFFFFE) begin
      fails++; $display("FAIL basic_lrck: got %h expected %h", lr, 64'h00000001_FFFFFFFE);
    end
    wait_load(1'b0, 20, n);
    wait_load(1'b0, 300, n);
    tests++;
    if (n !== 256) begin
      fails++; $display("FAIL frame_period: got %0d expected 256", n);
    end
  endtask

  task automatic test_underrun();
    logic [63:0] fr, lr;
    bit seen_u, seen_d;
    int n;
    do_reset();
    seen_u = 1'b0; seen_d = 1'b0;
    for (int i = 0; i < 768; i++) begin
      @(negedge clk);
      if (und) seen_u = 1'b1;
      if (data) seen_d = 1'b1;
    end
    tests++;
    if (seen_u !== 1'b0) begin
      fails++; $display("FAIL idle_underrun: got 1 expected 0");
    end
    tests++;
    if (seen_d !== 1'b0) begin
      fails++; $display("FAIL idle_data: got 1 expected 0");
    end
    pulse_strobe(24'h123456, 24'h654321);
    wait_load(1'b0, 300, n);
    capture(1'b0, fr, lr);
    tests++;
    if (fr !== 64'h12345600_65432100 || und !== 1'b0) begin
      fails++; $display("FAIL first_frame: got %h und=%b expected %h und=0", fr, und, 64'h12345600_65432100);
    end
    wait_load(1'b0, 20, n);
    tests++;
    if (und !== 1'b1) begin
      fails++; $display("FAIL underrun_set: got %b expected 1", und);
    end
    capture(1'b0, fr, lr);
    tests++;
    if (fr !== 64'h12345600_65432100) begin
      fails++; $display("FAIL repeat_frame: got %h expected %h", fr, 64'h12345600_65432100);
    end
    wait_load(1'b0, 20, n);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (und !== 1'b0) begin
      fails++; $display("FAIL underrun_clear: got %b expected 0", und);
    end
    wait_load(1'b0, 300, n);
    tests++;
    if (und !== 1'b1) begin
      fails++; $display("FAIL underrun_reassert: got %b expected 1", und);
    end
  endtask

  task automatic test_overrun();
    logic [63:0] fr, lr;
    int n;
    do_reset();
    repeat (9) @(negedge clk);
    pulse_strobe(24'h000011, 24'h000033);
    repeat (39) @(negedge clk);
    pulse_strobe(24'h000022, 24'h000044);
    tests++;
    if (ovr !== 1'b1) begin
      fails++; $display("FAIL overrun_set: got %b expected 1", ovr);
    end
    wait_load(1'b0, 300, n);
    capture(1'b0, fr, lr);
    tests++;
    if (fr !== 64'h00002200_00004400) begin
      fails++; $display("FAIL overrun_newer_wins: got %h expected %h", fr, 64'h00002200_00004400);
    end
    wait_load(1'b0, 20, n);
    repeat (10) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pulse_strobe(24'h000001, 24'h000002);
    tests++;
    if (ovr !== 1'b0) begin
      fails++; $display("FAIL overrun_first_strobe: got %b expected 0", ovr);
    end
    clear = 1'b1;
    pulse_strobe(24'h000003, 24'h000004);
    clear = 1'b0;
    tests++;
    if (ovr !== 1'b1) begin
      fails++; $display("FAIL overrun_set_beats_clear: got %b expected 1", ovr);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] fr, lr;
    int n;
    do_reset();
    repeat (3) @(negedge clk);
    strobe = 1'b1; l_in = 24'hABCDEF; r_in = 24'h135791;
    @(negedge clk);
    strobe = 1'b0;
    tests++;
    if (fload !== 1'b1) begin
      fails++; $display("FAIL bypass_align: frame_load got %b expected 1", fload);
    end
    capture(1'b0, fr, lr);
    tests++;
    if (fr !== 64'hABCDEF00_13579100 || und !== 1'b0 || ovr !== 1'b0) begin
      fails++; $display("FAIL bypass_frame: got %h und=%b ovr=%b expected %h und=0 ovr=0",
                        fr, und, ovr, 64'hABCDEF00_13579100);
    end
    // Strobe P1 one cycle before the load, then P2 on the load cycle itself.
    strobe = 1'b1; l_in = 24'h0F0F0F; r_in = 24'hF0F0F0;
    @(negedge clk);
    l_in = 24'h55AA55; r_in = 24'hAA55AA;
    @(negedge clk);
    strobe = 1'b0;
    tests++;
    if (fload !== 1'b1) begin
      fails++; $display("FAIL load_with_pending_align: frame_load got %b expected 1", fload);
    end
    capture(1'b0, fr, lr);
    tests++;
    if (fr !== 64'h0F0F0F00_F0F0F000 || ovr !== 1'b0) begin
      fails++; $display("FAIL load_with_pending: got %h ovr=%b expected %h ovr=0", fr, ovr, 64'h0F0F0F00_F0F0F000);
    end
    wait_load(1'b0, 20, n);
    capture(1'b0, fr, lr);
    tests++;
    if (fr !== 64'h55AA5500_AA55AA00 || und !== 1'b0) begin
      fails++; $display("FAIL pending_next_frame: got %h und=%b expected %h und=0", fr, und, 64'h55AA5500_AA55AA00);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    do_reset();
    wait_load(1'b0, 20, n);
    repeat (9) @(negedge clk);
    pulse_strobe(24'h111111, 24'h222222);
    repeat (9) @(negedge clk);
    pulse_strobe(24'h333333, 24'h444444);
    repeat (138) @(negedge clk);
    tests++;
    if (lrck !== 1'b1 || ovr !== 1'b1 || bclk !== 1'b1) begin
      fails++; $display("FAIL pre_reset_state: got lrck=%b ovr=%b bclk=%b expected 1 1 1", lrck, ovr, bclk);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bclk, lrck, data, fload, und, ovr} !== 6'b0) begin
      fails++; $display("FAIL async_reset: got %b expected 000000", {bclk, lrck, data, fload, und, ovr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; found = 1'b0;
    while (n < 20 && !found) begin
      @(negedge clk);
      n++;
      found = fload;
      if (n == 1) begin
        tests++;
        if (lrck !== 1'b0) begin
          fails++; $display("FAIL post_reset_lrck: got %b expected 0", lrck);
        end
      end
    end
    tests++;
    if (n !== 4 || !found) begin
      fails++; $display("FAIL post_reset_load: got %0d cycles expected 4", n);
    end
  endtask

  task automatic test_wide();
    logic [63:0] fr, lr;
    int n;
    do_reset();
    w_strobe = 1'b1; w_l = 32'hA50000F1; w_r = 32'h80000001;
    @(negedge clk);
    w_strobe = 1'b0;
    wait_load(1'b1, 20, n);
    tests++;
    if (n + 1 !== 2) begin
      fails++; $display("FAIL wide_first_load: got %0d cycles expected 2", n + 1);
    end
    capture(1'b1, fr, lr);
    tests++;
    if (fr !== 64'hA50000F1_80000001) begin
      fails++; $display("FAIL wide_frame: got %h expected %h", fr, 64'hA50000F1_80000001);
    end
    tests++;
    if (w_lrck !== 1'b0 || w_data !== 1'b1) begin
      fails++; $display("FAIL wide_lsb_at_bit0: got lrck=%b data=%b expected lrck=0 data=1", w_lrck, w_data);
    end
    wait_load(1'b1, 20, n);
    wait_load(1'b1, 200, n);
    tests++;
    if (n !== 128) begin
      fails++; $display("FAIL wide_period: got %0d expected 128", n);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_bypass();
    test_reset_mid();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
